// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared types and constants for the load/store unit.
//   - size_t      : request access size (byte / half / word / reserved)
//   - lsu_state_t : control FSM states of load_store_unit
//   - BYTE_LANES  : byte lanes per memory word
//   - size_align_err(): misalignment / reserved-size check for a request
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int BYTE_LANES = 4;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_MERGE_WR,
        ST_WR,
        ST_RESP,
        ST_ERR
    } lsu_state_t;

    // Halves must be 2-byte aligned, words 4-byte aligned; size 11 is never legal.
    function automatic logic size_align_err(input size_t size, input logic [1:0] offset);
        logic err;
        err = 1'b0;
        case (size)
            SZ_H:    err = offset[0];
            SZ_W:    err = (offset != 2'b00);
            SZ_RSV:  err = 1'b1;
            default: err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
//   Purely combinational little-endian lane steering.
//   Ports:
//     i_word     [31:0] memory word (read data or captured word)
//     i_wdata    [31:0] store data, right-aligned
//     i_offset   [1:0]  byte offset within the word (addr[1:0])
//     i_size            access size (lsu_pkg::size_t)
//     i_unsigned        zero-extend sub-word loads instead of sign-extend
//     o_rdata    [31:0] extracted and extended load data
//     o_merged   [31:0] i_word with the addressed lane(s) replaced by i_wdata
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  size_t       i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged
);

    logic [31:0] w_lane;

    // Bring the addressed lane down to bit 0.
    assign w_lane = i_word >> {i_offset, 3'b000};

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_rdata = i_word;
        case (i_size)
            SZ_B:    o_rdata = {{24{w_lane[7] & ~i_unsigned}}, w_lane[7:0]};
            SZ_H:    o_rdata = {{16{w_lane[15] & ~i_unsigned}}, w_lane[15:0]};
            default: o_rdata = i_word;
        endcase
    end

    always_comb begin
        o_merged = i_word;
        case (i_size)
            SZ_B: begin
                for (int l = 0; l < BYTE_LANES; l++) begin
                    if (2'(l) == i_offset) o_merged[8*l +: 8] = i_wdata[7:0];
                end
            end
            SZ_H: begin
                // Lanes {offset[1],0} and {offset[1],1} take the low and high data byte.
                for (int l = 0; l < BYTE_LANES; l++) begin
                    if (((l >> 1) & 1) == int'(i_offset[1]))
                        o_merged[8*l +: 8] = i_wdata[8*(l & 1) +: 8];
                end
            end
            SZ_W:    o_merged = i_wdata;
            default: o_merged = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW front end for a word-addressed
//   memory unit. One outstanding request; sub-word stores are done as
//   read-modify-write. Little-endian.
//   Configuration macro: LSU_RANGE_CHECK_EN -- when defined, any nonzero
//   req_addr bit above the memory's byte range is an error; otherwise the
//   upper bits are ignored and addresses alias.
//   Ports:
//     clk, rst (async, active-low)
//     req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata
//     resp_valid/resp_rdata/resp_err     one-cycle completion
//     mem_addr/mem_data_in/mem_data_out/mem_write_enable/mem_read_enable
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int addr_width = 10,
    parameter int data_width = 32,
    parameter int rd_latency = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [addr_width-1:0] mem_addr,
    output logic [31:0]           mem_data_in,
    input  logic [31:0]           mem_data_out,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable
);

    if (data_width != 32) begin : g_bad_data_width
        $error("load_store_unit: only data_width=32 is supported");
    end
    if (rd_latency < 1) begin : g_bad_rd_latency
        $error("load_store_unit: rd_latency must be at least 1");
    end

`ifdef LSU_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    localparam int CNT_W = (rd_latency > 1) ? $clog2(rd_latency) : 1;

    lsu_state_t            r_state;
    lsu_state_t            w_next_state;
    logic                  r_we;
    size_t                 r_size;
    logic                  r_unsigned;
    logic [1:0]            r_offset;
    logic [addr_width-1:0] r_waddr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_word;
    logic [31:0]           r_rdata;
    logic [CNT_W-1:0]      r_cnt;

    size_t                 w_size;
    logic                  w_accept;
    logic                  w_upper_nz;
    logic                  w_err;
    logic                  w_wait_done;
    logic [31:0]           w_align_word;
    logic [31:0]           w_load_data;
    logic [31:0]           w_merged;

    assign w_size      = size_t'(req_size);
    assign req_ready   = (r_state == ST_IDLE);
    assign w_accept    = req_valid && req_ready;
    assign w_upper_nz  = |(req_addr >> (addr_width + 2));
    assign w_err       = size_align_err(w_size, req_addr[1:0]) | (RANGE_CHECK & w_upper_nz);
    assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == '0);

    // During WAIT the aligner sees live read data (load extract); in MERGE_WR it
    // sees the captured word (store merge).
    assign w_align_word = (r_state == ST_WAIT) ? mem_data_out : r_word;

    lsu_lane_align u_lane_align (
        .i_word     (w_align_word),
        .i_wdata    (r_wdata),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_rdata    (w_load_data),
        .o_merged   (w_merged)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err)                         w_next_state = ST_ERR;
                    else if (req_we && w_size == SZ_W) w_next_state = ST_WR;
                    else                               w_next_state = ST_RD;
                end
            end
            ST_RD:       w_next_state = ST_WAIT;
            ST_WAIT:     if (w_wait_done) w_next_state = r_we ? ST_MERGE_WR : ST_RESP;
            ST_MERGE_WR: w_next_state = ST_RESP;
            ST_WR:       w_next_state = ST_RESP;
            ST_RESP:     w_next_state = ST_IDLE;
            ST_ERR:      w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_offset   <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_word     <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= w_size;
                r_unsigned <= req_unsigned;
                r_offset   <= req_addr[1:0];
                r_waddr    <= req_addr[addr_width+1:2];
                r_wdata    <= req_wdata;
                r_rdata    <= '0;
            end
            if (r_state == ST_RD) begin
                r_cnt <= CNT_W'(rd_latency - 1);
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_wait_done) begin
                r_word <= mem_data_out;
                if (!r_we) r_rdata <= w_load_data;
            end
        end
    end

    // All memory-side outputs decode from the state register, so a reset
    // removes any strobe in the same instant.
    assign mem_read_enable  = (r_state == ST_RD);
    assign mem_write_enable = (r_state == ST_MERGE_WR) || (r_state == ST_WR);
    assign mem_addr         = (r_state inside {ST_RD, ST_WAIT, ST_MERGE_WR, ST_WR, ST_RESP})
                              ? r_waddr : '0;
    assign mem_data_in      = (r_state == ST_MERGE_WR) ? w_merged :
                              (r_state == ST_WR)       ? r_wdata  : '0;

    assign resp_valid = (r_state == ST_RESP) || (r_state == ST_ERR);
    assign resp_err   = (r_state == ST_ERR);
    assign resp_rdata = (r_state == ST_RESP) ? r_rdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit (addr_width=10, rd_latency=1) with a
//   behavioural word memory, strobe counters and a response scoreboard.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_in;
    logic [31:0]   mem_data_out;
    logic          mem_write_enable;
    logic          mem_read_enable;

    always #5 clk = ~clk;

    load_store_unit #(.addr_width(AW), .data_width(32), .rd_latency(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable)
    );

    // Memory unit model: data valid one cycle after the read strobe, garbage otherwise.
    logic [31:0]   mem [0:(1<<AW)-1];
    int            n_rd = 0;
    int            n_wr = 0;
    logic [AW-1:0] last_wa = '0;
    logic [31:0]   last_wd = '0;

    always @(posedge clk) begin
        if (mem_write_enable === 1'b1) begin
            mem[mem_addr] <= mem_data_in;
            n_wr          <= n_wr + 1;
            last_wa       <= mem_addr;
            last_wd       <= mem_data_in;
        end
        if (mem_read_enable === 1'b1) begin
            mem_data_out <= mem[mem_addr];
            n_rd         <= n_rd + 1;
        end else begin
            mem_data_out <= 32'hDEAD_BEEF;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, push its expected response, then wait (bounded) for
    // the response and compare it against the popped entry.
    task automatic issue(input string tag, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   lat;
        int   rd0;
        int   wr0;
        bit   got;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_err ? 1 : (we ? ((sz == 2'b10) ? 2 : 4) : 3);
        e.nrd   = (exp_err || (we && sz == 2'b10)) ? 0 : 1;
        e.nwr   = (!exp_err && we) ? 1 : 0;
        sb_q.push_back(e);

        lat = 0;
        while (req_ready !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".ready"}, 32'(req_ready), 32'd1);

        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        rd0          = n_rd;
        wr0          = n_wr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat       = 1;
        got       = 1'b0;
        while (lat <= 20) begin
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end

        e = sb_q.pop_front();
        check({tag, ".resp_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, ".latency"}, 32'(lat), 32'(e.lat));
            check({tag, ".rdata"}, resp_rdata, e.rdata);
            check({tag, ".err"}, 32'(resp_err), 32'(e.err));
            check({tag, ".reads"}, 32'(n_rd - rd0), 32'(e.nrd));
            check({tag, ".writes"}, 32'(n_wr - wr0), 32'(e.nwr));
        end
        @(negedge clk);
    endtask

    // Start a request and return once the DUT is in the cycle where the
    // requested strobe is high (bounded).
    task automatic start_and_wait_strobe(input string tag, input logic [31:0] addr,
                                         input logic [31:0] wdata, input bit want_write);
        int n;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b01;
        req_unsigned = 1'b0;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (((want_write ? mem_write_enable : mem_read_enable) !== 1'b1) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".strobe_reached"}, 32'(n < 10), 32'd1);
    endtask

    initial begin
        int wr_before;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);

        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.resp_err", 32'(resp_err), 32'd0);
        check("reset.resp_rdata", resp_rdata, 32'h0);
        check("reset.mem_addr", 32'(mem_addr), 32'd0);
        check("reset.mem_data_in", mem_data_in, 32'h0);
        check("reset.mem_strobes", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Word store then load back.
        issue("sw_0x10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
        check("sw_0x10.waddr", 32'(last_wa), 32'd4);
        check("sw_0x10.wdata", last_wd, 32'h1122_3344);
        issue("lw_0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122_3344, 1'b0);

        // Sub-word stores: read-modify-write.
        issue("sb_0x11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 32'h0, 1'b0);
        check("sb_0x11.wdata", last_wd, 32'h1122_AB44);
        check("sb_0x11.waddr", 32'(last_wa), 32'd4);
        issue("sh_0x12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h5555_BEEF, 32'h0, 1'b0);
        check("sh_0x12.wdata", last_wd, 32'hBEEF_AB44);
        issue("sb_0x13", 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF77, 32'h0, 1'b0);
        issue("lw_0x10_b", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h77EF_AB44, 1'b0);
        issue("sh_0x10", 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_1234, 32'h0, 1'b0);
        check("sh_0x10.wdata", last_wd, 32'h77EF_1234);

        // Load extraction and extension.
        issue("sw_0x20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_8080, 32'h0, 1'b0);
        issue("lb_0x20", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'hFFFF_FF80, 1'b0);
        issue("lbu_0x20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h0000_0080, 1'b0);
        issue("lh_0x20", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'hFFFF_8080, 1'b0);
        issue("lhu_0x20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_8080, 1'b0);
        issue("lh_0x22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_0000, 1'b0);
        issue("sw_0x24", 1'b1, 2'b10, 1'b0, 32'h24, 32'h7F80_C301, 32'h0, 1'b0);
        issue("lb_0x27", 1'b0, 2'b00, 1'b0, 32'h27, 32'h0, 32'h0000_007F, 1'b0);
        issue("lh_0x26", 1'b0, 2'b01, 1'b0, 32'h26, 32'h0, 32'h0000_7F80, 1'b0);
        issue("lbu_0x26", 1'b0, 2'b00, 1'b1, 32'h26, 32'h0, 32'h0000_0080, 1'b0);
        issue("lb_0x25", 1'b0, 2'b00, 1'b0, 32'h25, 32'h0, 32'hFFFF_FFC3, 1'b0);
        issue("lwu_0x24", 1'b0, 2'b10, 1'b1, 32'h24, 32'h0, 32'h7F80_C301, 1'b0);

        // Errors: no strobe, rdata 0, response one cycle after accept.
        issue("err_lh_0x03", 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1);
        issue("err_sw_0x02", 1'b1, 2'b10, 1'b0, 32'h02, 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue("err_size11", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1);
        issue("err_sh_0x11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_FFFF, 32'h0, 1'b1);
        issue("lw_0x10_after_err", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h77EF_1234, 1'b0);

        // Reset during RD and during MERGE_WR of an SH.
        issue("sw_0x40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_BABE, 32'h0, 1'b0);
        wr_before = n_wr;
        start_and_wait_strobe("rst_rd", 32'h42, 32'h0000_1234, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_rd.read_enable", 32'(mem_read_enable), 32'd0);
        check("rst_rd.write_enable", 32'(mem_write_enable), 32'd0);
        check("rst_rd.req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        start_and_wait_strobe("rst_mwr", 32'h42, 32'h0000_5678, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_mwr.write_enable", 32'(mem_write_enable), 32'd0);
        check("rst_mwr.resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mwr.req_ready", 32'(req_ready), 32'd1);
        check("rst.no_write", 32'(n_wr - wr_before), 32'd0);
        check("rst.mem_word", mem[16], 32'hCAFE_BABE);
        issue("lw_0x40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFE_BABE, 1'b0);

        // Upper address bits beyond the memory range.
        issue("sw_0x00", 1'b1, 2'b10, 1'b0, 32'h00, 32'h5A5A_0001, 32'h0, 1'b0);
`ifdef LSU_RANGE_CHECK_EN
        issue("lw_0x1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
`else
        issue("lw_0x1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h5A5A_0001, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
